alu_rs_scheduler: RTL

- Reservation station and issue scheduler that owns the shared combinational ALU in the Tomasulo core.
- Accepts dispatched ALU-class µops (arith, logic, shift, compare, branch compare, lui/auipc/jal/jalr address add) from the decoder and holds them until both operands are valid.
- Wakes operands by snooping two CDB ports: ALU result and LSB result.
- Issues at most one ready µop per cycle into the ALU's status, OpCode, rs1, rs2 and ROB_Number inputs.

---
 rtl/alu_rs_scheduler.sv | 214 +++++++++++++++++++++
 1 files changed

// File: rtl/alu_rs_scheduler.sv
// alu_rs_scheduler: reservation station and single-issue scheduler in front of
// the shared combinational ALU.
//   clk_in, rst_in (sync, active-low), rdy_in (freeze when low), clear (flush)
//   disp_*        : dispatch request from the decoder (one uop per cycle)
//   rs_full       : all entries busy, combinational from the busy vector
//   alu_cdb_*     : ALU result broadcast (operand wakeup)
//   lsb_cdb_*     : LSB result broadcast (operand wakeup)
//   issue_*       : registered issue to the ALU (status/OpCode/rs1/rs2/ROB_Number)

// One station entry: holds a uop and snoops both CDB ports for missing operands.
module alu_rs_entry #(
  parameter int TAG_W = 4,
  parameter int OP_W  = 6,
  parameter int XLEN  = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             alloc,
  input  logic             free,
  input  logic [OP_W-1:0]  d_op,
  input  logic [XLEN-1:0]  d_vj,
  input  logic             d_qj_busy,
  input  logic [TAG_W-1:0] d_qj,
  input  logic [XLEN-1:0]  d_vk,
  input  logic             d_qk_busy,
  input  logic [TAG_W-1:0] d_qk,
  input  logic [TAG_W-1:0] d_rob,
  input  logic             alu_cdb_valid,
  input  logic [TAG_W-1:0] alu_cdb_tag,
  input  logic [XLEN-1:0]  alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [TAG_W-1:0] lsb_cdb_tag,
  input  logic [XLEN-1:0]  lsb_cdb_val,
  output logic             busy,
  output logic             ready,
  output logic [OP_W-1:0]  op,
  output logic [XLEN-1:0]  vj,
  output logic [XLEN-1:0]  vk,
  output logic [TAG_W-1:0] rob
);
  logic             qj_busy, qk_busy;
  logic [TAG_W-1:0] qj, qk;

  assign ready = busy && !qj_busy && !qk_busy;

  always_ff @(posedge clk_in) begin
    if (!rst_in || clear) begin
      busy    <= 1'b0;
      qj_busy <= 1'b0;
      qk_busy <= 1'b0;
    end else if (rdy_in) begin
      if (alloc) begin
        busy    <= 1'b1;
        op      <= d_op;
        vj      <= d_vj;
        qj_busy <= d_qj_busy;
        qj      <= d_qj;
        vk      <= d_vk;
        qk_busy <= d_qk_busy;
        qk      <= d_qk;
        rob     <= d_rob;
      end else if (busy) begin
        // a granted entry has no pending operands, so wakeup cannot race the free
        if (free) busy <= 1'b0;
        if (qj_busy) begin
          if (alu_cdb_valid && alu_cdb_tag == qj) begin
            vj <= alu_cdb_val; qj_busy <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_tag == qj) begin
            vj <= lsb_cdb_val; qj_busy <= 1'b0;
          end
        end
        if (qk_busy) begin
          if (alu_cdb_valid && alu_cdb_tag == qk) begin
            vk <= alu_cdb_val; qk_busy <= 1'b0;
          end else if (lsb_cdb_valid && lsb_cdb_tag == qk) begin
            vk <= lsb_cdb_val; qk_busy <= 1'b0;
          end
        end
      end
    end
  end
endmodule

module alu_rs_scheduler #(
  parameter int RS_SIZE = 16,
  parameter int IDX_W   = 4,
  parameter int TAG_W   = 4,
  parameter int OP_W    = 6,
  parameter int XLEN    = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             clear,
  input  logic             disp_valid,
  input  logic [OP_W-1:0]  disp_op,
  input  logic [XLEN-1:0]  disp_vj,
  input  logic             disp_qj_busy,
  input  logic [TAG_W-1:0] disp_qj,
  input  logic [XLEN-1:0]  disp_vk,
  input  logic             disp_qk_busy,
  input  logic [TAG_W-1:0] disp_qk,
  input  logic [TAG_W-1:0] disp_rob,
  output logic             rs_full,
  input  logic             alu_cdb_valid,
  input  logic [TAG_W-1:0] alu_cdb_tag,
  input  logic [XLEN-1:0]  alu_cdb_val,
  input  logic             lsb_cdb_valid,
  input  logic [TAG_W-1:0] lsb_cdb_tag,
  input  logic [XLEN-1:0]  lsb_cdb_val,
  output logic             issue_valid,
  output logic [OP_W-1:0]  issue_op,
  output logic [XLEN-1:0]  issue_rs1,
  output logic [XLEN-1:0]  issue_rs2,
  output logic [TAG_W-1:0] issue_rob
);
  logic [RS_SIZE-1:0] busy, ready, alloc, free;
  logic [OP_W-1:0]    e_op  [RS_SIZE];
  logic [XLEN-1:0]    e_vj  [RS_SIZE];
  logic [XLEN-1:0]    e_vk  [RS_SIZE];
  logic [TAG_W-1:0]   e_rob [RS_SIZE];

  logic               gnt_vld;
  logic [IDX_W-1:0]   gnt_idx, alloc_idx;
  logic               disp_acc;

  // dispatch-time forwarding: ALU port wins, tags never collide across ports
  logic               j_alu_hit, j_lsb_hit, k_alu_hit, k_lsb_hit;
  logic [XLEN-1:0]    f_vj, f_vk;
  logic               f_qj_busy, f_qk_busy;

  assign j_alu_hit = disp_qj_busy && alu_cdb_valid && alu_cdb_tag == disp_qj;
  assign j_lsb_hit = disp_qj_busy && lsb_cdb_valid && lsb_cdb_tag == disp_qj;
  assign k_alu_hit = disp_qk_busy && alu_cdb_valid && alu_cdb_tag == disp_qk;
  assign k_lsb_hit = disp_qk_busy && lsb_cdb_valid && lsb_cdb_tag == disp_qk;

  assign f_vj      = j_alu_hit ? alu_cdb_val : j_lsb_hit ? lsb_cdb_val : disp_vj;
  assign f_vk      = k_alu_hit ? alu_cdb_val : k_lsb_hit ? lsb_cdb_val : disp_vk;
  assign f_qj_busy = disp_qj_busy && !j_alu_hit && !j_lsb_hit;
  assign f_qk_busy = disp_qk_busy && !k_alu_hit && !k_lsb_hit;

  // full is judged on pre-edge busy, so a same-edge free never admits a dispatch
  assign rs_full  = &busy;
  assign disp_acc = disp_valid && !rs_full;

  // lowest-index ready entry and lowest-index free entry (descending scan)
  always_comb begin
    gnt_vld   = 1'b0;
    gnt_idx   = '0;
    alloc_idx = '0;
    for (int i = RS_SIZE - 1; i >= 0; i--) begin
      if (ready[i]) begin
        gnt_vld = 1'b1;
        gnt_idx = IDX_W'(i);
      end
      if (!busy[i]) alloc_idx = IDX_W'(i);
    end
  end

  for (genvar i = 0; i < RS_SIZE; i++) begin : g_ent
    assign alloc[i] = disp_acc && alloc_idx == IDX_W'(i);
    assign free[i]  = gnt_vld && gnt_idx == IDX_W'(i);

    alu_rs_entry #(.TAG_W(TAG_W), .OP_W(OP_W), .XLEN(XLEN)) u_ent (
      .clk_in        (clk_in),
      .rst_in        (rst_in),
      .rdy_in        (rdy_in),
      .clear         (clear),
      .alloc         (alloc[i]),
      .free          (free[i]),
      .d_op          (disp_op),
      .d_vj          (f_vj),
      .d_qj_busy     (f_qj_busy),
      .d_qj          (disp_qj),
      .d_vk          (f_vk),
      .d_qk_busy     (f_qk_busy),
      .d_qk          (disp_qk),
      .d_rob         (disp_rob),
      .alu_cdb_valid (alu_cdb_valid),
      .alu_cdb_tag   (alu_cdb_tag),
      .alu_cdb_val   (alu_cdb_val),
      .lsb_cdb_valid (lsb_cdb_valid),
      .lsb_cdb_tag   (lsb_cdb_tag),
      .lsb_cdb_val   (lsb_cdb_val),
      .busy          (busy[i]),
      .ready         (ready[i]),
      .op            (e_op[i]),
      .vj            (e_vj[i]),
      .vk            (e_vk[i]),
      .rob           (e_rob[i])
    );
  end

  // issue register: data holds when nothing is granted
  always_ff @(posedge clk_in) begin
    if (!rst_in || clear) begin
      issue_valid <= 1'b0;
      issue_op    <= '0;
      issue_rs1   <= '0;
      issue_rs2   <= '0;
      issue_rob   <= '0;
    end else if (rdy_in) begin
      issue_valid <= gnt_vld;
      if (gnt_vld) begin
        issue_op  <= e_op[gnt_idx];
        issue_rs1 <= e_vj[gnt_idx];
        issue_rs2 <= e_vk[gnt_idx];
        issue_rob <= e_rob[gnt_idx];
      end
    end
  end
endmodule
